// File: rtl/clk_enable_gen.sv
// Clock-enable generator with PLL lock supervision: NUM_CLOCKS programmable
// divided strobes and square references, released only after a filtered lock.
module clk_enable_gen #(
  parameter int NUM_CLOCKS  = 2,
  parameter int CNT_W       = 16,
  parameter int LOCK_FILTER = 1024,
  parameter int DIV_RESET   = 2
) (
  input  logic                        refclk,
  input  logic                        rst,
  input  logic                        pll_locked,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [NUM_CLOCKS*CNT_W-1:0] cfg_div,
  input  logic [NUM_CLOCKS*CNT_W-1:0] cfg_phase,
  output logic [NUM_CLOCKS-1:0]       clk_en,
  output logic [NUM_CLOCKS-1:0]       clk_sq,
  output logic                        locked
);

  localparam int               FW          = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
  localparam logic [FW-1:0]    FILTER_LAST = FW'(LOCK_FILTER - 1);
  localparam logic [FW-1:0]    FONE        = FW'(1);
  localparam logic [CNT_W-1:0] DIV_INIT    = CNT_W'(DIV_RESET);
  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

  typedef enum logic [1:0] {UNLOCKED, FILTER, RUN, ALIGN} state_t;

  state_t           state, state_next;
  logic [FW-1:0]    fcnt, fcnt_next;
  logic             lk_meta, lk_s;
  logic             cfg_fire;
  logic             run;
  logic [CNT_W-1:0] div_r   [NUM_CLOCKS];
  logic [CNT_W-1:0] phase_r [NUM_CLOCKS];
  logic [CNT_W-1:0] cnt     [NUM_CLOCKS];

  // pll_locked is asynchronous to refclk
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      lk_meta <= 1'b0;
      lk_s    <= 1'b0;
    end else begin
      lk_meta <= pll_locked;
      lk_s    <= lk_meta;
    end
  end

  assign cfg_ready = (state != ALIGN);
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign run       = (state == RUN);
  assign locked    = run;

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      state <= UNLOCKED;
      fcnt  <= '0;
    end else begin
      state <= state_next;
      fcnt  <= fcnt_next;
    end
  end

  always_comb begin
    state_next = state;
    fcnt_next  = fcnt;
    case (state)
      UNLOCKED: begin
        fcnt_next = '0;
        if (lk_s) state_next = FILTER;
      end
      FILTER: begin
        if (!lk_s) begin
          state_next = UNLOCKED;
          fcnt_next  = '0;
        end else if (fcnt == FILTER_LAST) begin
          state_next = ALIGN;
          fcnt_next  = '0;
        end else begin
          fcnt_next = fcnt + FONE;
        end
      end
      ALIGN: state_next = lk_s ? RUN : UNLOCKED;
      RUN: begin
        // lock loss wins; a config offered in the same cycle is still stored
        if (!lk_s)         state_next = UNLOCKED;
        else if (cfg_fire) state_next = ALIGN;
      end
      default: state_next = UNLOCKED;
    endcase
  end

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        div_r[i]   <= DIV_INIT;
        phase_r[i] <= '0;
        cnt[i]     <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        if (cfg_fire) begin
          div_r[i]   <= cfg_div[i*CNT_W +: CNT_W];
          phase_r[i] <= cfg_phase[i*CNT_W +: CNT_W];
        end
        case (state)
          // out-of-range phase starts at 0; a disabled channel always does
          ALIGN: cnt[i] <= (phase_r[i] >= div_r[i]) ? '0 : phase_r[i];
          RUN: begin
            if (div_r[i] == '0 || cnt[i] == div_r[i] - ONE) cnt[i] <= '0;
            else                                            cnt[i] <= cnt[i] + ONE;
          end
          default: cnt[i] <= '0;
        endcase
      end
    end
  end

  always_comb begin
    clk_en = '0;
    clk_sq = '0;
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      if (run && div_r[i] != '0) begin
        clk_en[i] = (cnt[i] == div_r[i] - ONE);
        clk_sq[i] = (cnt[i] >= (div_r[i] >> 1));
      end
    end
  end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed bench for clk_enable_gen: lock filter, reconfiguration, disabled
// and constant channels, lock loss with pending config, and async reset.
module tb_clk_enable_gen;

  logic        refclk = 1'b0;
  logic        rst;
  logic        pll_locked;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_div;
  logic [31:0] cfg_phase;
  logic [1:0]  clk_en;
  logic [1:0]  clk_sq;
  logic        locked;

  int errors = 0;
  int checks = 0;

  clk_enable_gen #(
    .NUM_CLOCKS(2), .CNT_W(16), .LOCK_FILTER(8), .DIV_RESET(2)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_div(cfg_div), .cfg_phase(cfg_phase),
    .clk_en(clk_en), .clk_sq(clk_sq), .locked(locked)
  );

  always #5 refclk = ~refclk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [15:0] div1, input logic [15:0] div0,
                               input logic [15:0] ph1, input logic [15:0] ph0);
    cfg_valid = valid;
    cfg_div   = {div1, div0};
    cfg_phase = {ph1, ph0};
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge refclk);
  endtask

  // locked must rise exactly 11 cycles after the edge that first samples pll_locked
  task automatic expectRelock(input string tag);
    step(11);
    checkOutput({tag, "_locked_early"}, 32'(locked), 32'd0);
    step(1);
    checkOutput({tag, "_locked"}, 32'(locked), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst        = 1'b0;
    pll_locked = 1'b0;
    applyStimulus(1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
    step(3);
    checkOutput("rst_clk_en", 32'(clk_en), 32'd0);
    checkOutput("rst_clk_sq", 32'(clk_sq), 32'd0);
    checkOutput("rst_locked", 32'(locked), 32'd0);
    checkOutput("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    rst = 1'b1;
    step(2);

    pll_locked = 1'b1;
    step(11);
    checkOutput("acq_locked_early", 32'(locked), 32'd0);
    checkOutput("acq_align_ready", 32'(cfg_ready), 32'd0);
    step(1);
    checkOutput("acq_locked", 32'(locked), 32'd1);
    for (int k = 0; k < 6; k++) begin
      checkOutput($sformatf("div2_en_%0d", k), 32'(clk_en), (k % 2 == 1) ? 32'd3 : 32'd0);
      checkOutput($sformatf("div2_sq_%0d", k), 32'(clk_sq), (k % 2 == 1) ? 32'd3 : 32'd0);
      step(1);
    end

    pll_locked = 1'b0;
    step(2);
    checkOutput("loss_locked_held", 32'(locked), 32'd1);
    step(1);
    checkOutput("loss_locked", 32'(locked), 32'd0);
    checkOutput("loss_clk_en", 32'(clk_en), 32'd0);
    checkOutput("loss_clk_sq", 32'(clk_sq), 32'd0);

    // two-cycle dropout in the middle of the filter window
    pll_locked = 1'b1;
    step(5);
    checkOutput("glitch_pre_locked", 32'(locked), 32'd0);
    pll_locked = 1'b0;
    step(2);
    pll_locked = 1'b1;
    expectRelock("glitch");

    applyStimulus(1'b1, 16'd5, 16'd3, 16'd4, 16'd0);
    checkOutput("cfg_ready_run", 32'(cfg_ready), 32'd1);
    step(1);
    cfg_valid = 1'b0;
    checkOutput("align_ready", 32'(cfg_ready), 32'd0);
    checkOutput("align_clk_en", 32'(clk_en), 32'd0);
    checkOutput("align_clk_sq", 32'(clk_sq), 32'd0);
    checkOutput("align_locked", 32'(locked), 32'd0);
    step(1);
    for (int k = 0; k < 15; k++) begin
      checkOutput($sformatf("d53_en_%0d", k), 32'(clk_en),
                  32'({(k % 5 == 0), (k % 3 == 2)}));
      checkOutput($sformatf("d53_sq_%0d", k), 32'(clk_sq),
                  32'({((4 + k) % 5 >= 2), (k % 3 != 0)}));
      step(1);
    end

    // held valid: ready alternates because ALIGN blocks every second cycle
    applyStimulus(1'b1, 16'd5, 16'd3, 16'd4, 16'd0);
    checkOutput("hold_ready_0", 32'(cfg_ready), 32'd1);
    step(1);
    checkOutput("hold_ready_1", 32'(cfg_ready), 32'd0);
    step(1);
    checkOutput("hold_ready_2", 32'(cfg_ready), 32'd1);
    step(1);
    checkOutput("hold_ready_3", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b0;
    step(1);

    applyStimulus(1'b1, 16'd1, 16'd0, 16'd0, 16'd5);
    step(1);
    cfg_valid = 1'b0;
    step(1);
    for (int k = 0; k < 6; k++) begin
      checkOutput($sformatf("d10_en_%0d", k), 32'(clk_en), 32'd2);
      checkOutput($sformatf("d10_sq_%0d", k), 32'(clk_sq), 32'd2);
      step(1);
    end

    // ch0 phase 7 exceeds div 4 and must start from 0
    applyStimulus(1'b1, 16'd4, 16'd4, 16'd3, 16'd7);
    step(1);
    cfg_valid = 1'b0;
    step(1);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("d44_en_%0d", k), 32'(clk_en),
                  32'({((3 + k) % 4 == 3), (k % 4 == 3)}));
      checkOutput($sformatf("d44_sq_%0d", k), 32'(clk_sq),
                  32'({((3 + k) % 4 >= 2), (k % 4 >= 2)}));
      step(1);
    end

    // config offered in the same cycle the lock loss reaches the FSM
    pll_locked = 1'b0;
    step(2);
    checkOutput("drop_locked_held", 32'(locked), 32'd1);
    applyStimulus(1'b1, 16'd2, 16'd6, 16'd1, 16'd0);
    step(1);
    cfg_valid = 1'b0;
    checkOutput("drop_locked", 32'(locked), 32'd0);
    checkOutput("drop_ready", 32'(cfg_ready), 32'd1);
    checkOutput("drop_clk_en", 32'(clk_en), 32'd0);
    step(2);
    pll_locked = 1'b1;
    expectRelock("drop");
    for (int k = 0; k < 12; k++) begin
      checkOutput($sformatf("d62_en_%0d", k), 32'(clk_en),
                  32'({((1 + k) % 2 == 1), (k % 6 == 5)}));
      checkOutput($sformatf("d62_sq_%0d", k), 32'(clk_sq),
                  32'({((1 + k) % 2 == 1), (k % 6 >= 3)}));
      step(1);
    end

    checkOutput("pre_reset_en", 32'(clk_en), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_clk_en", 32'(clk_en), 32'd0);
    checkOutput("async_clk_sq", 32'(clk_sq), 32'd0);
    checkOutput("async_locked", 32'(locked), 32'd0);
    checkOutput("async_ready", 32'(cfg_ready), 32'd1);
    step(1);
    rst = 1'b1;
    expectRelock("rst");
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("divrst_en_%0d", k), 32'(clk_en), (k % 2 == 1) ? 32'd3 : 32'd0);
      checkOutput($sformatf("divrst_sq_%0d", k), 32'(clk_sq), (k % 2 == 1) ? 32'd3 : 32'd0);
      step(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
